// File: rtl/pipe_hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Forward-select encodings match the EX operand mux inputs.
package pipe_hazard_unit_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic v;
    logic ld;
  } sb_flags_t;

endpackage

// File: rtl/pipe_hazard_unit_reg_match.sv
// Compares one ID source register against one in-flight destination.
// Register 0 is hardwired and never produces a hit.
module reg_match #(
  parameter int REG_W = 5
) (
  input  logic             v,
  input  logic             use_src,
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] rw,
  output logic             hit
);

  assign hit = v & use_src & (|src) & (rw == src);

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage pipeline.
// Tracks in-flight writers EX..WB and drives stall/bubble/flush/fwd.
module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int REG_W     = 5,
  parameter int DEPTH     = 3,
  parameter int FWD_EN    = 1,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_rw,
  input  logic             id_reg_wr,
  input  logic             id_mem_to_reg,
  input  logic             ex_br_taken,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int LIM = DEPTH - WB_BYPASS;

  logic [DEPTH-1:0] sb_v;
  logic [DEPTH-1:0] sb_ld;
  logic [REG_W-1:0] sb_rw [DEPTH];
  logic [DEPTH-1:0] hit_a;
  logic [DEPTH-1:0] hit_b;
  logic [DEPTH-1:0] lim_mask;

  for (genvar k = 0; k < DEPTH; k++) begin : g_sb
    sb_flags_t        f_q;
    sb_flags_t        f_d;
    logic [REG_W-1:0] rw_q;
    logic [REG_W-1:0] rw_d;

    if (k == 0) begin : g_ex
      assign f_d.v  = id_valid & id_reg_wr
                    & ~(stall | flush);
      assign f_d.ld = id_mem_to_reg;
      assign rw_d   = id_rw;
    end else begin : g_shift
      assign f_d.v  = sb_v[k-1];
      assign f_d.ld = sb_ld[k-1];
      assign rw_d   = sb_rw[k-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        f_q <= '0;
      end else begin
        f_q <= f_d;
      end
      rw_q <= rw_d;
    end

    assign sb_v[k]     = f_q.v;
    assign sb_ld[k]    = f_q.ld;
    assign sb_rw[k]    = rw_q;
    assign lim_mask[k] = (k < LIM);

    reg_match #(.REG_W(REG_W)) u_match_a (
      .v       (f_q.v),
      .use_src (id_use_rs),
      .src     (id_rs),
      .rw      (rw_q),
      .hit     (hit_a[k])
    );

    reg_match #(.REG_W(REG_W)) u_match_b (
      .v       (f_q.v),
      .use_src (id_use_rt),
      .src     (id_rt),
      .rw      (rw_q),
      .hit     (hit_b[k])
    );
  end

  logic raw_hz;

  always_comb begin
    raw_hz = 1'b0;
    if (FWD_EN != 0) begin
      raw_hz = (hit_a[0] | hit_b[0]) & sb_ld[0];
    end else begin
      raw_hz = |((hit_a | hit_b) & lim_mask);
    end
  end

  // Flush wins over stall; both are quiet while in reset.
  assign flush  = ex_br_taken & ~rst;
  assign stall  = id_valid & raw_hz & ~flush & ~rst;
  assign bubble = stall & ~flush;

  logic       a_mem, a_wb;
  logic       b_mem, b_wb;
  logic [1:0] fa_d, fb_d;

  assign a_mem = hit_a[0] & ~sb_ld[0];
  assign a_wb  = hit_a[1] & ~a_mem;
  assign b_mem = hit_b[0] & ~sb_ld[0];
  assign b_wb  = hit_b[1] & ~b_mem;

  always_comb begin
    fa_d = FWD_RF;
    unique case (1'b1)
      a_mem:   fa_d = FWD_MEM;
      a_wb:    fa_d = FWD_WB;
      default: fa_d = FWD_RF;
    endcase
  end

  always_comb begin
    fb_d = FWD_RF;
    unique case (1'b1)
      b_mem:   fb_d = FWD_MEM;
      b_wb:    fb_d = FWD_WB;
      default: fb_d = FWD_RF;
    endcase
  end

  logic fwd_off;
  assign fwd_off = stall | flush | (FWD_EN == 0);

  always_ff @(posedge clk) begin
    if (rst || fwd_off) begin
      fwd_a <= FWD_RF;
      fwd_b <= FWD_RF;
    end else begin
      fwd_a <= fa_d;
      fwd_b <= fb_d;
    end
  end

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && !(&stall_cnt)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (flush && !(&flush_cnt)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Randomized bench: forwarding and non-forwarding instances checked
// against an in-flight instruction list model.
module tb_pipe_hazard_unit;

  localparam int D = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_rw;
  logic       id_use_rs, id_use_rt;
  logic       id_reg_wr, id_mem_to_reg;
  logic       ex_br_taken;

  logic        st1, bu1, fl1;
  logic [1:0]  fa1, fb1;
  logic [15:0] sc1, fc1;
  logic        st0, bu0, fl0;
  logic [1:0]  fa0, fb0;
  logic [1:0]  sc0, fc0;

  always #5 clk = ~clk;

  pipe_hazard_unit dut_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rw(id_rw), .id_reg_wr(id_reg_wr),
    .id_mem_to_reg(id_mem_to_reg), .ex_br_taken(ex_br_taken),
    .stall(st1), .bubble(bu1), .flush(fl1),
    .fwd_a(fa1), .fwd_b(fb1),
    .stall_cnt(sc1), .flush_cnt(fc1)
  );

  pipe_hazard_unit #(.FWD_EN(0), .CNT_W(2)) dut_nofwd (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rw(id_rw), .id_reg_wr(id_reg_wr),
    .id_mem_to_reg(id_mem_to_reg), .ex_br_taken(ex_br_taken),
    .stall(st0), .bubble(bu0), .flush(fl0),
    .fwd_a(fa0), .fwd_b(fb0),
    .stall_cnt(sc0), .flush_cnt(fc0)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: index 1 = forwarding core, 0 = stall-only core.
  // Each instance holds the instructions now in EX, MEM, WB.
  typedef struct {
    bit       wr;
    bit [4:0] dst;
    bit       load;
  } inst_t;

  inst_t flight [2][D];
  int    m_fa [2], m_fb [2], m_sc [2], m_fc [2];
  int    cmax [2] = '{3, 65535};

  function automatic bit produces(int i, int k, bit u, bit [4:0] s);
    return flight[i][k].wr && u && (s != 0) && (flight[i][k].dst == s);
  endfunction

  function automatic bit want_stall(int i);
    if (rst || ex_br_taken || !id_valid) return 0;
    if (i == 1)
      return flight[i][0].load &&
             (produces(i, 0, id_use_rs, id_rs) ||
              produces(i, 0, id_use_rt, id_rt));
    // without forwarding, wait until the writer reaches WB
    for (int k = 0; k < D - 1; k++)
      if (produces(i, k, id_use_rs, id_rs) ||
          produces(i, k, id_use_rt, id_rt))
        return 1;
    return 0;
  endfunction

  function automatic int pick(int i, bit u, bit [4:0] s);
    if (produces(i, 0, u, s) && !flight[i][0].load) return 1;
    if (produces(i, 1, u, s)) return 2;
    return 0;
  endfunction

  task automatic cycle(input bit r, input bit v,
                       input bit [4:0] rs, input bit [4:0] rt,
                       input bit urs, input bit urt,
                       input bit [4:0] rw, input bit wr,
                       input bit ld, input bit br);
    bit es [2];
    bit ef;
    @(negedge clk);
    rst = r; id_valid = v; id_rs = rs; id_rt = rt;
    id_use_rs = urs; id_use_rt = urt; id_rw = rw;
    id_reg_wr = wr; id_mem_to_reg = ld; ex_br_taken = br;
    #1;
    ef = br && !r;
    for (int i = 0; i < 2; i++) es[i] = want_stall(i);
    chk("stall_fwd", st1, es[1]);
    chk("bubble_fwd", bu1, es[1]);
    chk("flush_fwd", fl1, ef);
    chk("stall_nofwd", st0, es[0]);
    chk("bubble_nofwd", bu0, es[0]);
    chk("flush_nofwd", fl0, ef);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        for (int k = 0; k < D; k++) flight[i][k] = '{0, 0, 0};
        m_fa[i] = 0; m_fb[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
      end else begin
        if (i == 1 && !es[i] && !ef) begin
          m_fa[i] = pick(i, urs, rs);
          m_fb[i] = pick(i, urt, rt);
        end else begin
          m_fa[i] = 0; m_fb[i] = 0;
        end
        for (int k = D - 1; k > 0; k--) flight[i][k] = flight[i][k-1];
        flight[i][0] = '{v && wr && !es[i] && !ef, rw, ld};
        if (es[i] && m_sc[i] < cmax[i]) m_sc[i]++;
        if (ef && m_fc[i] < cmax[i]) m_fc[i]++;
      end
    end
    @(posedge clk);
    #1;
    chk("fwd_a_fwd", fa1, m_fa[1]);
    chk("fwd_b_fwd", fb1, m_fb[1]);
    chk("stall_cnt_fwd", sc1, m_sc[1]);
    chk("flush_cnt_fwd", fc1, m_fc[1]);
    chk("fwd_a_nofwd", fa0, m_fa[0]);
    chk("fwd_b_nofwd", fb0, m_fb[0]);
    chk("stall_cnt_nofwd", sc0, m_sc[0]);
    chk("flush_cnt_nofwd", fc0, m_fc[0]);
  endtask

  task automatic nop();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; id_valid = 0; id_rs = 0; id_rt = 0; id_rw = 0;
    id_use_rs = 0; id_use_rt = 0; id_reg_wr = 0;
    id_mem_to_reg = 0; ex_br_taken = 0;
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 1, 1, 1, 1, 1, 0);

    // lw r2 ; add r3,r2,r4 (held one cycle by the stall)
    cycle(0, 1, 0, 0, 1, 0, 2, 1, 1, 0);
    cycle(0, 1, 2, 4, 1, 1, 3, 1, 0, 0);
    cycle(0, 1, 2, 4, 1, 1, 3, 1, 0, 0);
    nop(); nop(); nop();

    // add r1 ; sub r5,r1,r1
    cycle(0, 1, 2, 3, 1, 1, 1, 1, 0, 0);
    cycle(0, 1, 1, 1, 1, 1, 5, 1, 0, 0);
    nop(); nop(); nop();

    // add r1 ; add r1 ; or r6,r1,r0
    cycle(0, 1, 2, 3, 1, 1, 1, 1, 0, 0);
    cycle(0, 1, 2, 3, 1, 1, 1, 1, 0, 0);
    cycle(0, 1, 1, 0, 1, 1, 6, 1, 0, 0);
    nop(); nop(); nop();

    // branch taken over a load-use
    cycle(0, 1, 0, 0, 1, 0, 7, 1, 1, 0);
    cycle(0, 1, 7, 0, 1, 0, 8, 1, 0, 1);
    nop(); nop(); nop();

    // reset in the middle of a stall
    cycle(0, 1, 0, 0, 0, 0, 9, 1, 1, 0);
    cycle(0, 1, 9, 9, 1, 1, 3, 1, 0, 0);
    cycle(1, 1, 9, 9, 1, 1, 3, 1, 0, 0);
    cycle(0, 1, 9, 9, 1, 1, 3, 1, 0, 0);

    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 59) == 0,
            $urandom_range(0, 7) != 0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom_range(0, 5) != 0, $urandom_range(0, 2) != 0,
            5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
